// File: rtl/nibble_packer_pkg.sv
// Shared defaults and types for the nibble packer.
// Pops narrow queue beats and packs them into wide words.
package nibble_packer_pkg;

  // Default configuration: 4-bit beats from the FIFO queue, four per word.
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_RATIO      = 4;

  // Derived widths. The count is one bit wider than the index so that it
  // can hold the value RATIO itself (a full word's beat count).
  localparam int DEF_OUT_WIDTH  = DEF_DATA_WIDTH * DEF_RATIO;
  localparam int DEF_CNT_WIDTH  = $clog2(DEF_RATIO) + 1;

  // Beat count in the default configuration.
  typedef logic [DEF_CNT_WIDTH-1:0] beat_cnt_t;

endpackage

// File: rtl/nibble_packer.sv
// nibble_packer: downstream consumer of the 4-bit FIFO queue.
// Pops RATIO consecutive beats through the queue's dequeue handshake and
// presents them as one wide word (first beat in the LSBs) on a valid/ready
// port. A holding register lets packing of the next word continue while the
// downstream stage stalls; only the final beat of a word waits for the slot.
//
// Optional build macro NIBBLE_PACKER_FLUSH_EN adds a flush input that emits
// a partial word (zero-padded) and an out_count output giving the number of
// beats in the presented word.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int RATIO      = DEF_RATIO,
  localparam int OUT_WIDTH  = DATA_WIDTH * RATIO,
  localparam int CNT_WIDTH  = $clog2(RATIO) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  deq_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  deq,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef NIBBLE_PACKER_FLUSH_EN
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  out_count,
`endif
  output logic [OUT_WIDTH-1:0]  dout
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(RATIO - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_next;
  logic [OUT_WIDTH-1:0] out_reg;
  logic                 out_valid_q;

  logic                 slot_free;
  logic                 accept;
  logic                 word_done;
  logic                 flush_fire;   // a partial word is emitted this cycle
  logic                 beat_block;   // beats are refused (pending flush)

  // The output slot can take a new word if empty or draining this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Beats 0..RATIO-2 always go in; the final beat needs a free slot.
  assign deq = deq_valid && !rst && !beat_block && (cnt != LAST_IDX || slot_free);

  assign accept    = deq && deq_valid;
  assign word_done = accept && (cnt == LAST_IDX);

  assign out_valid = out_valid_q;
  assign dout      = out_reg;

`ifdef NIBBLE_PACKER_FLUSH_EN
  logic                 flush_pending;
  logic                 flush_req;
  logic [CNT_WIDTH-1:0] cnt_eff;
  logic [CNT_WIDTH-1:0] out_count_q;

  // Beat count including any beat taken this cycle (ranges 0..RATIO).
  assign cnt_eff    = cnt + CNT_WIDTH'(accept);
  assign flush_req  = flush || flush_pending;
  // A completing full word takes priority; an empty accumulator is ignored.
  assign flush_fire = flush_req && slot_free && !word_done && (cnt_eff != '0);
  assign beat_block = flush_pending;
  assign out_count  = out_count_q;

  // Flush bookkeeping: hold an un-served flush and track the word's beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pending <= 1'b0;
      out_count_q   <= '0;
    end else begin
      flush_pending <= flush_req && !slot_free && (cnt_eff != '0);
      if (word_done) begin
        out_count_q <= CNT_WIDTH'(RATIO);
      end else if (flush_fire) begin
        out_count_q <= cnt_eff;
      end
    end
  end
`else
  assign flush_fire = 1'b0;
  assign beat_block = 1'b0;
`endif

  // Accumulator with the incoming beat dropped into its lane.
  always_comb begin
    // NOTE: default assignment first so no path leaves acc_next unassigned (no latch).
    acc_next = acc;
    if (accept) begin
      for (int i = 0; i < RATIO; i++) begin
        if (cnt == CNT_WIDTH'(i)) begin
          acc_next[i*DATA_WIDTH +: DATA_WIDTH] = din;
        end
      end
    end
  end

  // Accumulator, beat count and output holding register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      out_reg     <= '0;
      out_valid_q <= 1'b0;
    end else if (word_done || flush_fire) begin
      // Slot is free here, so loading the new word also covers a same-cycle
      // drain of the old one: back-to-back words with no bubble.
      out_reg     <= acc_next;
      out_valid_q <= 1'b1;
      cnt         <= '0;
      acc         <= '0;
    end else begin
      if (accept) begin
        acc <= acc_next;
        cnt <= cnt + ONE;
      end
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (default 4x4-bit config).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// Build with NIBBLE_PACKER_FLUSH_EN to also exercise the flush feature.
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        deq_valid;
  logic [3:0]  din;
  logic        deq;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
`ifdef NIBBLE_PACKER_FLUSH_EN
  logic        flush;
  logic [2:0]  out_count;
`endif

  int checks   = 0;
  int failures = 0;

  nibble_packer dut (
    .clk       (clk),
    .rst       (rst),
    .deq_valid (deq_valid),
    .din       (din),
    .deq       (deq),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef NIBBLE_PACKER_FLUSH_EN
    .flush     (flush),
    .out_count (out_count),
`endif
    .dout      (dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; deq_valid = 1'b0; din = 4'h0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    checks++; if (deq !== 1'b0) begin failures++; $display("FAIL reset_deq got=%b exp=0", deq); end
    deq_valid = 1'b1; din = 4'hF;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (deq !== 1'b0) begin failures++; $display("FAIL reset_deq_held cyc=%0d got=%b exp=0", i, deq); end
      tick();
    end
    deq_valid = 1'b0; rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      deq_valid = 1'b1; din = 4'(b);
      #1;
      checks++; if (deq !== 1'b1) begin failures++; $display("FAIL single_deq beat=%0d got=%b exp=1", b, deq); end
      tick();
    end
    deq_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (dout !== 16'h4321) begin failures++; $display("FAIL single_dout got=%h exp=4321", dout); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      deq_valid = 1'b1; din = 4'(b);
      tick();
    end
    checks++; if (out_valid !== 1'b1 || dout !== 16'h4321) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/4321", out_valid, dout); end
    for (int b = 5; b <= 7; b++) begin
      din = 4'(b);
      #1;
      checks++; if (deq !== 1'b1) begin failures++; $display("FAIL bp_accept beat=%0d got=%b exp=1", b, deq); end
      tick();
      checks++; if (out_valid !== 1'b1 || dout !== 16'h4321) begin failures++; $display("FAIL bp_hold beat=%0d got=%b/%h exp=1/4321", b, out_valid, dout); end
    end
    din = 4'h8;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (deq !== 1'b0) begin failures++; $display("FAIL bp_stall_deq cyc=%0d got=%b exp=0", i, deq); end
      tick();
      checks++; if (out_valid !== 1'b1 || dout !== 16'h4321) begin failures++; $display("FAIL bp_stall_hold cyc=%0d got=%b/%h exp=1/4321", i, out_valid, dout); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (deq !== 1'b1) begin failures++; $display("FAIL bp_release_deq got=%b exp=1", deq); end
    tick();
    deq_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dout !== 16'h8765) begin failures++; $display("FAIL bp_no_bubble got=%b/%h exp=1/8765", out_valid, dout); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [15:0] exp_d;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      deq_valid = 1'b1; din = 4'(k + 1);
      tick();
      exp_v = (k == 3) || (k == 7);
      exp_d = (k == 3) ? 16'h4321 : 16'h8765;
      checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (dout !== exp_d) begin failures++; $display("FAIL b2b_dout k=%0d got=%h exp=%h", k, dout, exp_d); end
      end
    end
    deq_valid = 1'b0;
    tick();
  endtask

  task automatic test_empty_input();
    out_ready = 1'b1;
    deq_valid = 1'b1; din = 4'h1; tick();
    din = 4'h2; tick();
    deq_valid = 1'b0; din = 4'hE;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, out_valid); end
    end
    deq_valid = 1'b1; din = 4'h3; tick();
    din = 4'h4; tick();
    deq_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dout !== 16'h4321) begin failures++; $display("FAIL idle_resume got=%b/%h exp=1/4321", out_valid, dout); end
    tick();
  endtask

  task automatic test_reset_discard();
    out_ready = 1'b1;
    deq_valid = 1'b1; din = 4'h9; tick();
    din = 4'hA; tick();
    deq_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL discard_reset_valid got=%b exp=0", out_valid); end
    for (int b = 10; b <= 13; b++) begin
      deq_valid = 1'b1; din = 4'(b);
      tick();
    end
    deq_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dout !== 16'hDCBA) begin failures++; $display("FAIL discard_dout got=%b/%h exp=1/dcba", out_valid, dout); end
    tick();
  endtask

`ifdef NIBBLE_PACKER_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b1; flush = 1'b0;
    deq_valid = 1'b1; din = 4'h5; tick();
    din = 4'h6; tick();
    deq_valid = 1'b0; flush = 1'b1; tick();
    checks++; if (out_valid !== 1'b1 || dout !== 16'h0065) begin failures++; $display("FAIL flush_dout got=%b/%h exp=1/0065", out_valid, dout); end
    checks++; if (out_count !== 3'd2) begin failures++; $display("FAIL flush_count got=%0d exp=2", out_count); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
    // Flush while the slot is busy: held pending, beats refused meanwhile.
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      deq_valid = 1'b1; din = 4'(b);
      tick();
    end
    checks++; if (out_count !== 3'd4 || dout !== 16'h4321) begin failures++; $display("FAIL flush_full_count got=%0d/%h exp=4/4321", out_count, dout); end
    din = 4'h5; tick();
    din = 4'h6; flush = 1'b1; tick();
    flush = 1'b0; din = 4'h7;
    #1;
    checks++; if (deq !== 1'b0) begin failures++; $display("FAIL flush_pending_deq got=%b exp=0", deq); end
    out_ready = 1'b1;
    #1;
    checks++; if (deq !== 1'b0) begin failures++; $display("FAIL flush_pending_deq2 got=%b exp=0", deq); end
    tick();
    deq_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dout !== 16'h0065 || out_count !== 3'd2) begin failures++; $display("FAIL flush_pending_emit got=%b/%h/%0d exp=1/0065/2", out_valid, dout, out_count); end
    tick();
  endtask
`endif

  initial begin
`ifdef NIBBLE_PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_empty_input();
    test_reset_discard();
`ifdef NIBBLE_PACKER_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
